// File: rtl/sqrt_sum_fsm.sv
// sqrt_sum_fsm: client-side controller for a shared pipelined isqrt unit.
// Issues three radicands back-to-back and sums the three roots as they return.
// Returns are counted rather than timed, so any fixed isqrt latency works,
// including a purely combinational unit.
module sqrt_sum_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        arg_vld,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic        busy,
  output logic        res_vld,
  output logic [17:0] res,
  output logic        isqrt_x_vld,
  output logic [31:0] isqrt_x,
  input  logic        isqrt_y_vld,
  input  logic [15:0] isqrt_y
);

  typedef enum logic [2:0] {IDLE, ISSUE_A, ISSUE_B, ISSUE_C, WAIT} state_t;

  state_t      state;
  logic [31:0] b_hold;
  logic [31:0] c_hold;
  logic [17:0] acc;
  logic [1:0]  ret_cnt;

  // Sum never exceeds 3*65535, so 18 bits always hold it without wrap.
  function automatic logic [17:0] zext_root(input logic [15:0] y);
    return {2'b00, y};
  endfunction

  logic take_ret;
  logic last_ret;

  // A return is accepted only while a triple is in flight and fewer than three have arrived.
  assign take_ret = (state != IDLE) && isqrt_y_vld && (ret_cnt != 2'd3);
  assign last_ret = take_ret && (ret_cnt == 2'd2);

  // Issue sequencing, return accumulation and completion, all registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      res_vld     <= 1'b0;
      res         <= '0;
      isqrt_x_vld <= 1'b0;
      isqrt_x     <= '0;
      b_hold      <= '0;
      c_hold      <= '0;
      acc         <= '0;
      ret_cnt     <= '0;
    end else begin
      res_vld <= 1'b0;

      case (state)
        IDLE: begin
          isqrt_x_vld <= 1'b0;
          if (arg_vld) begin
            b_hold      <= b;
            c_hold      <= c;
            acc         <= '0;
            ret_cnt     <= '0;
            isqrt_x     <= a;
            isqrt_x_vld <= 1'b1;
            busy        <= 1'b1;
            state       <= ISSUE_A;
          end
        end
        ISSUE_A: begin
          isqrt_x     <= b_hold;
          isqrt_x_vld <= 1'b1;
          state       <= ISSUE_B;
        end
        ISSUE_B: begin
          isqrt_x     <= c_hold;
          isqrt_x_vld <= 1'b1;
          state       <= ISSUE_C;
        end
        ISSUE_C: begin
          // isqrt_x keeps the last radicand; only the strobe drops.
          isqrt_x_vld <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          isqrt_x_vld <= 1'b0;
        end
        default: begin
          isqrt_x_vld <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase

      // Returns may overlap issue cycles when the isqrt latency is short.
      if (take_ret) begin
        acc     <= acc + zext_root(isqrt_y);
        ret_cnt <= ret_cnt + 2'd1;
      end

      // Third return closes the triple; this overrides the issue-path next state.
      if (last_ret) begin
        res     <= acc + zext_root(isqrt_y);
        res_vld <= 1'b1;
        busy    <= 1'b0;
        state   <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_sqrt_sum_fsm.sv
// Testbench for sqrt_sum_fsm with a behavioural isqrt stub of selectable latency.
module tb_sqrt_sum_fsm;

  logic        clk;
  logic        rst_n;
  logic        arg_vld;
  logic [31:0] a, b, c;
  logic        busy;
  logic        res_vld;
  logic [17:0] res;
  logic        isqrt_x_vld;
  logic [31:0] isqrt_x;
  logic        isqrt_y_vld;
  logic [15:0] isqrt_y;

  int          lat_sel;
  logic        stub_clr;
  logic        inj_vld;
  logic [15:0] inj_y;
  logic        stub_vld;
  logic [15:0] stub_y;
  logic [16:0] pipe [0:15];

  int n_chk;
  int n_err;

  sqrt_sum_fsm dut (
    .clk         (clk),
    .rst         (rst_n),
    .arg_vld     (arg_vld),
    .a           (a),
    .b           (b),
    .c           (c),
    .busy        (busy),
    .res_vld     (res_vld),
    .res         (res),
    .isqrt_x_vld (isqrt_x_vld),
    .isqrt_x     (isqrt_x),
    .isqrt_y_vld (isqrt_y_vld),
    .isqrt_y     (isqrt_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] isqrt_fn(input logic [31:0] x);
    logic [15:0] r;
    logic [15:0] t;
    logic [31:0] sq;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      t  = r | (16'd1 << i);
      sq = {16'd0, t} * {16'd0, t};
      if (sq <= x) r = t;
    end
    return r;
  endfunction

  // Stub delay line: entry k holds what the unit returns k+1 cycles after issue.
  always_ff @(posedge clk) begin
    if (stub_clr) begin
      for (int i = 0; i < 16; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {isqrt_x_vld, isqrt_fn(isqrt_x)};
      for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Latency 0 is a combinational unit; otherwise tap the delay line.
  always_comb begin
    stub_vld = 1'b0;
    stub_y   = '0;
    if (lat_sel == 0) begin
      stub_vld = isqrt_x_vld;
      stub_y   = isqrt_fn(isqrt_x);
    end else begin
      stub_vld = pipe[lat_sel-1][16];
      stub_y   = pipe[lat_sel-1][15:0];
    end
  end

  assign isqrt_y_vld = stub_vld | inj_vld;
  assign isqrt_y     = inj_vld ? inj_y : stub_y;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one triple at the current cycle (cycle 0) and follow it to res_vld.
  // pulse_cyc > 0 drives a 100/100/100 arg_vld strobe at that cycle while busy.
  task automatic run_triple(input string nm, input logic [31:0] va, input logic [31:0] vb,
                            input logic [31:0] vc, input int lat, input logic [17:0] exp_res,
                            input int exp_cyc, input int pulse_cyc, input bit post_step);
    int          cyc;
    bit          got;
    int          busy_cnt;
    int          xv_cnt;
    logic [31:0] xs [0:2];
    logic        busy_at_done;
    lat_sel  = lat;
    a        = va;
    b        = vb;
    c        = vc;
    arg_vld  = 1'b1;
    cyc      = 0;
    got      = 1'b0;
    busy_cnt = 0;
    xv_cnt   = 0;
    busy_at_done = 1'b1;
    for (int k = 0; k < 3; k++) xs[k] = '0;
    while (!got && cyc < 60) begin
      step();
      cyc++;
      arg_vld = 1'b0;
      if (cyc == pulse_cyc) begin
        a = 32'd100;
        b = 32'd100;
        c = 32'd100;
        arg_vld = 1'b1;
      end
      if (busy) busy_cnt++;
      if (isqrt_x_vld) begin
        if (xv_cnt < 3) xs[xv_cnt] = isqrt_x;
        xv_cnt++;
      end
      if (res_vld) begin
        got = 1'b1;
        busy_at_done = busy;
      end
    end
    arg_vld = 1'b0;
    chk({nm, " res_vld seen"}, 64'(got), 64'd1);
    chk({nm, " latency"}, 64'(cyc), 64'(exp_cyc));
    chk({nm, " res"}, 64'(res), 64'(exp_res));
    chk({nm, " busy cycles"}, 64'(busy_cnt), 64'(exp_cyc - 1));
    chk({nm, " busy at done"}, 64'(busy_at_done), 64'd0);
    chk({nm, " issue count"}, 64'(xv_cnt), 64'd3);
    chk({nm, " x seq a"}, 64'(xs[0]), 64'(va));
    chk({nm, " x seq b"}, 64'(xs[1]), 64'(vb));
    chk({nm, " x seq c"}, 64'(xs[2]), 64'(vc));
    if (post_step) begin
      step();
      chk({nm, " res_vld one cycle"}, 64'(res_vld), 64'd0);
      chk({nm, " res holds"}, 64'(res), 64'(exp_res));
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    int          lat;
    logic [17:0] res;
    int          cyc;
  } vec_t;

  vec_t tbl [0:7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int res_vld_cnt;
    n_chk    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    arg_vld  = 1'b0;
    a        = '0;
    b        = '0;
    c        = '0;
    lat_sel  = 16;
    stub_clr = 1'b1;
    inj_vld  = 1'b0;
    inj_y    = '0;

    tbl[0] = '{"sq149_L16",   32'd1,          32'd4,          32'd9,  16, 18'd6,      20};
    tbl[1] = '{"max_L16",     32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 16, 18'h2FFFD, 20};
    tbl[2] = '{"zero_L16",    32'd0,          32'd0,          32'd0,  16, 18'd0,      20};
    tbl[3] = '{"151617_L0",   32'd15,         32'd16,         32'd17, 0,  18'd11,     4};
    tbl[4] = '{"151617_L1",   32'd15,         32'd16,         32'd17, 1,  18'd11,     5};
    tbl[5] = '{"mix_L3",      32'd100,        32'd99,         32'd2,  3,  18'd20,     7};
    tbl[6] = '{"edge_L2",     32'd65536,      32'd65535,      32'd3,  2,  18'd512,    6};
    tbl[7] = '{"big_L5",      32'd1000000,    32'd999999,     32'd8,  5,  18'd2001,   9};

    repeat (3) step();
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset res_vld", 64'(res_vld), 64'd0);
    chk("reset res", 64'(res), 64'd0);
    chk("reset x_vld", 64'(isqrt_x_vld), 64'd0);
    chk("reset x", 64'(isqrt_x), 64'd0);
    rst_n    = 1'b1;
    stub_clr = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 8; i++) begin
      run_triple(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].lat,
                 tbl[i].res, tbl[i].cyc, 0, 1'b1);
      repeat (20) step();
    end

    // arg_vld while busy is dropped; arg_vld on the res_vld cycle is taken.
    run_triple("busy_ignore", 32'd1, 32'd4, 32'd9, 16, 18'd6, 20, 5, 1'b0);
    run_triple("back_to_back", 32'd4, 32'd16, 32'd25, 16, 18'd11, 20, 0, 1'b1);
    repeat (20) step();

    // Reset at cycle 10, release at cycle 12; stale returns reach an idle block.
    lat_sel = 16;
    a = 32'd1;
    b = 32'd4;
    c = 32'd9;
    arg_vld = 1'b1;
    step();
    arg_vld = 1'b0;
    repeat (9) step();
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst res_vld", 64'(res_vld), 64'd0);
    chk("midrst res", 64'(res), 64'd0);
    chk("midrst x_vld", 64'(isqrt_x_vld), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    res_vld_cnt = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (res_vld) res_vld_cnt++;
      if (busy) res_vld_cnt++;
    end
    chk("midrst no completion", 64'(res_vld_cnt), 64'd0);
    chk("midrst res after stale", 64'(res), 64'd0);
    run_triple("after_rst", 32'd4, 32'd4, 32'd4, 16, 18'd6, 20, 0, 1'b1);
    repeat (20) step();

    // Spurious returns while idle.
    inj_y   = 16'hFFFF;
    inj_vld = 1'b1;
    res_vld_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (res_vld) res_vld_cnt++;
      if (busy) res_vld_cnt++;
    end
    inj_vld = 1'b0;
    step();
    chk("idle spurious no activity", 64'(res_vld_cnt), 64'd0);
    chk("idle spurious res", 64'(res), 64'd6);
    run_triple("after_spur", 32'd9, 32'd9, 32'd9, 0, 18'd9, 4, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
